btn_debounce_fsm: RTL

- Button-conditioning stage that consumes the slow_clk square wave produced by the slow-clock divider (toggles every 12,500,001 in_clk cycles).
- Samples a raw game pushbutton once per slow_clk toggle, all in the in_clk domain.
- Produces:
  - a clean level;
  - single-cycle press and release pulses;
  - an optional auto-repeat pulse while the button is held.
- Sits between the board pushbuttons and the game control FSM (guess entry / increment).

---
 rtl/btn_pkg.sv | 16 +
 rtl/sync_2ff.sv | 29 ++
 rtl/btn_debounce_fsm.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the pushbutton debouncer: FSM state encoding and
// counter widths sized from the legal parameter maxima.
package btn_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE         = 2'd0;
  localparam logic [STATE_W-1:0] PRESS_WAIT   = 2'd1;
  localparam logic [STATE_W-1:0] PRESSED      = 2'd2;
  localparam logic [STATE_W-1:0] RELEASE_WAIT = 2'd3;

  // STABLE_SAMPLES <= 15 and REPEAT_DELAY/RATE <= 255, so these never wrap.
  localparam int CNT_W = 4;
  localparam int REP_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_debounce_fsm.sv
// Pushbutton debouncer: samples the synchronized button on every slow_clk
// edge and emits a clean level plus press/release/auto-repeat pulses.
module btn_debounce_fsm
  import btn_pkg::*;
#(
  parameter int STABLE_SAMPLES = 2,
  parameter int REPEAT_DELAY   = 4,
  parameter int REPEAT_RATE    = 2,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic in_clk,
  input  logic rst,
  input  logic slow_clk,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_SAMPLES);
  localparam logic [REP_W-1:0] DELAY_C  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] RATE_C   = REP_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  logic btn_s, slow_s;

  sync_2ff u_sync_btn (
    .clk (in_clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  sync_2ff u_sync_slow (
    .clk (in_clk),
    .rst (rst),
    .d   (slow_clk),
    .q   (slow_s)
  );

  logic               slow_prev_q, slow_prev_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic               rate_phase_q, rate_phase_d;
  logic               level_q, level_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               repeat_q, repeat_d;

  logic               tick;
  logic               sample;
  logic [CNT_W-1:0]   cnt_inc;
  logic [REP_W-1:0]   rep_inc;

  // Both slow_clk edges produce a one-cycle tick.
  assign tick    = slow_s ^ slow_prev_q;
  assign sample  = btn_s;
  assign cnt_inc = cnt_q + CNT_ONE;
  assign rep_inc = rep_cnt_q + REP_ONE;

  always_comb begin
    slow_prev_d  = slow_s;
    state_d      = state_q;
    cnt_d        = cnt_q;
    rep_cnt_d    = rep_cnt_q;
    rate_phase_d = rate_phase_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    repeat_d     = 1'b0;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (sample) begin
            if (STABLE_C == CNT_ONE) begin
              state_d      = PRESSED;
              press_d      = 1'b1;
              cnt_d        = '0;
              rep_cnt_d    = '0;
              rate_phase_d = 1'b0;
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = CNT_ONE;
            end
          end
        end

        PRESS_WAIT: begin
          if (sample) begin
            if (cnt_inc == STABLE_C) begin
              state_d      = PRESSED;
              press_d      = 1'b1;
              cnt_d        = '0;
              rep_cnt_d    = '0;
              rate_phase_d = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end

        PRESSED: begin
          if (!sample) begin
            if (STABLE_C == CNT_ONE) begin
              state_d   = IDLE;
              release_d = 1'b1;
              cnt_d     = '0;
            end else begin
              state_d = RELEASE_WAIT;
              cnt_d   = CNT_ONE;
            end
          end else if (REPEAT_EN) begin
            // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE.
            if (rep_inc == (rate_phase_q ? RATE_C : DELAY_C)) begin
              repeat_d     = 1'b1;
              rep_cnt_d    = '0;
              rate_phase_d = 1'b1;
            end else begin
              rep_cnt_d = rep_inc;
            end
          end
        end

        RELEASE_WAIT: begin
          if (!sample) begin
            if (cnt_inc == STABLE_C) begin
              state_d   = IDLE;
              release_d = 1'b1;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // A release glitch restarts the hold delay so no repeat fires early.
            state_d      = PRESSED;
            cnt_d        = '0;
            rep_cnt_d    = '0;
            rate_phase_d = 1'b0;
          end
        end

        default: begin
          state_d      = IDLE;
          cnt_d        = '0;
          rep_cnt_d    = '0;
          rate_phase_d = 1'b0;
        end
      endcase
    end

    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      slow_prev_q  <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      rep_cnt_q    <= '0;
      rate_phase_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      repeat_q     <= 1'b0;
    end else begin
      slow_prev_q  <= slow_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      rate_phase_q <= rate_phase_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      repeat_q     <= repeat_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule
